// File: rtl/shadow_dump_collector.sv
// Capture+dump session controller: packs root serial chains into chain-tagged words via FWFT FIFO.
// Last bit -> word_vld in 2 cycles when empty; dump_en drops the cycle after any holding reg fills.
module shadow_dump_collector #(
  parameter int CHAINS     = 1,
  parameter int WORD_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  localparam int CW = (CHAINS > 1) ? $clog2(CHAINS) : 1,
  localparam int BW = $clog2(WORD_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  capture_en,
  output logic [CHAINS-1:0]     dump_en,
  input  logic [CHAINS-1:0]     chains_in,
  input  logic [CHAINS-1:0]     chains_in_vld,
  input  logic [CHAINS-1:0]     chains_in_done,
  output logic [WORD_WIDTH-1:0] word_out,
  output logic [CW-1:0]         word_chain,
  output logic [BW-1:0]         word_bits,
  output logic                  word_vld,
  input  logic                  word_rdy,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_CAPT, S_DUMP, S_DRAIN} state_t;

  state_t                r_state;
  logic                  r_capture_en, r_done, r_overrun;
  logic [CHAINS-1:0]     r_dump_en;
  logic [WORD_WIDTH-1:0] r_shift     [CHAINS];
  logic [BW-1:0]         r_cnt       [CHAINS];
  logic [WORD_WIDTH-1:0] r_hold_dat  [CHAINS];
  logic [BW-1:0]         r_hold_bits [CHAINS];
  logic [CHAINS-1:0]     r_hold_vld;
  logic [CW-1:0]         r_ptr;
  logic [WORD_WIDTH-1:0] r_fifo_dat   [FIFO_DEPTH];
  logic [CW-1:0]         r_fifo_chain [FIFO_DEPTH];
  logic [BW-1:0]         r_fifo_bits  [FIFO_DEPTH];
  logic [AW-1:0]         r_wr, r_rd;
  logic [AW:0]           r_count;

  logic [WORD_WIDTH-1:0] w_shift_next [CHAINS];
  logic [WORD_WIDTH-1:0] w_move_dat   [CHAINS];
  logic [BW-1:0]         w_move_bits  [CHAINS];
  logic [CHAINS-1:0]     w_move, w_hold_free;
  logic                  w_cnt_zero, w_gnt_vld, w_push, w_pop;
  logic [CW-1:0]         w_gnt, w_ptr_next;
  int                    w_idx;

  // Round-robin search starting at r_ptr over occupied holding registers.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    w_idx     = 0;
    for (int k = 0; k < CHAINS; k++) begin
      w_idx = (int'(r_ptr) + k) % CHAINS;
      if (!w_gnt_vld && r_hold_vld[CW'(w_idx)]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = CW'(w_idx);
      end
    end
  end

  assign w_pop      = (r_count != '0) && word_rdy;
  assign w_push     = w_gnt_vld && ((r_count != FULL_CNT) || w_pop);
  assign w_ptr_next = (w_gnt == CW'(CHAINS-1)) ? '0 : w_gnt + CW'(1);

  always_comb begin
    w_cnt_zero = 1'b1;
    for (int c = 0; c < CHAINS; c++) begin
      w_shift_next[c] = r_shift[c] | (WORD_WIDTH'(chains_in[c]) << r_cnt[c]);
      w_move[c]       = (r_state == S_DUMP) &&
                        ((chains_in_vld[c] && (r_cnt[c] == BW'(WORD_WIDTH-1))) ||
                         (!chains_in_vld[c] && chains_in_done[c] && (r_cnt[c] != '0)));
      w_move_dat[c]   = chains_in_vld[c] ? w_shift_next[c] : r_shift[c];
      w_move_bits[c]  = chains_in_vld[c] ? BW'(WORD_WIDTH) : r_cnt[c];
      // A hold being drained this cycle can be refilled in the same cycle.
      w_hold_free[c]  = !r_hold_vld[c] || (w_push && (w_gnt == CW'(c)));
      if (r_cnt[c] != '0) w_cnt_zero = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_capture_en <= 1'b0;
      r_done       <= 1'b0;
      r_overrun    <= 1'b0;
      r_dump_en    <= '0;
      r_hold_vld   <= '0;
      for (int c = 0; c < CHAINS; c++) begin
        r_shift[c]     <= '0;
        r_cnt[c]       <= '0;
        r_hold_dat[c]  <= '0;
        r_hold_bits[c] <= '0;
      end
    end else begin
      r_capture_en <= 1'b0;
      r_done       <= 1'b0;
      r_dump_en    <= {CHAINS{(r_state == S_DUMP) && (r_hold_vld == '0)}};
      case (r_state)
        S_IDLE: if (start) begin
          r_state      <= S_CAPT;
          r_capture_en <= 1'b1;
          r_overrun    <= 1'b0;
        end
        S_CAPT:  r_state <= S_DUMP;
        S_DUMP:  if ((&chains_in_done) && w_cnt_zero && (r_hold_vld == '0)) r_state <= S_DRAIN;
        S_DRAIN: if (r_count == '0) begin
          r_state <= S_IDLE;
          r_done  <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
      if ((r_state != S_DUMP) && (chains_in_vld != '0)) r_overrun <= 1'b1;
      for (int c = 0; c < CHAINS; c++) begin
        if (w_push && (w_gnt == CW'(c))) r_hold_vld[c] <= 1'b0;
        if (w_move[c]) begin
          r_shift[c] <= '0;
          r_cnt[c]   <= '0;
          if (w_hold_free[c]) begin
            r_hold_dat[c]  <= w_move_dat[c];
            r_hold_bits[c] <= w_move_bits[c];
            r_hold_vld[c]  <= 1'b1;
          end else begin
            r_overrun <= 1'b1;
          end
        end else if ((r_state == S_DUMP) && chains_in_vld[c]) begin
          r_shift[c] <= w_shift_next[c];
          r_cnt[c]   <= r_cnt[c] + BW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_ptr   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_dat[i]   <= '0;
        r_fifo_chain[i] <= '0;
        r_fifo_bits[i]  <= '0;
      end
    end else begin
      if (w_push) begin
        r_fifo_dat[r_wr]   <= r_hold_dat[w_gnt];
        r_fifo_chain[r_wr] <= w_gnt;
        r_fifo_bits[r_wr]  <= r_hold_bits[w_gnt];
        r_wr               <= r_wr + AW'(1);
        r_ptr              <= w_ptr_next;
      end
      if (w_pop) r_rd <= r_rd + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign capture_en = r_capture_en;
  assign dump_en    = r_dump_en;
  assign done       = r_done;
  assign overrun    = r_overrun;
  assign busy       = (r_state != S_IDLE);
  assign word_vld   = (r_count != '0);
  assign word_out   = r_fifo_dat[r_rd];
  assign word_chain = r_fifo_chain[r_rd];
  assign word_bits  = r_fifo_bits[r_rd];

endmodule

// File: tb/tb_shadow_dump_collector.sv
// Scoreboard bench for shadow_dump_collector with two chains and 8-bit words.
module tb_shadow_dump_collector;

  logic       clk = 1'b0;
  logic       rst, start, word_rdy;
  logic [1:0] chains_in, chains_in_vld, chains_in_done;
  logic       capture_en, word_chain, word_vld, busy, done, overrun;
  logic [1:0] dump_en;
  logic [7:0] word_out;
  logic [3:0] word_bits;

  typedef struct packed {
    logic [7:0] d;
    logic       c;
    logic [3:0] b;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_bad    = 0;

  shadow_dump_collector #(.CHAINS(2), .WORD_WIDTH(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .capture_en(capture_en), .dump_en(dump_en),
    .chains_in(chains_in), .chains_in_vld(chains_in_vld), .chains_in_done(chains_in_done),
    .word_out(word_out), .word_chain(word_chain), .word_bits(word_bits),
    .word_vld(word_vld), .word_rdy(word_rdy), .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // One clock; any word handed over at the coming edge is checked against the scoreboard.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (word_vld === 1'b1 && word_rdy === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected: got word=%0h chain=%0d bits=%0d, none expected", word_out, word_chain, word_bits);
      end else begin
        e = exp_q.pop_front();
        if ({word_out, word_chain, word_bits} !== e) begin
          n_bad++;
          $display("FAIL sb_word: got word=%0h chain=%0d bits=%0d, expected word=%0h chain=%0d bits=%0d",
                   word_out, word_chain, word_bits, e.d, e.c, e.b);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [7:0] d, input logic c, input logic [3:0] b);
    exp_t e;
    e.d = d; e.c = c; e.b = b;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic start_session();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Upstream model: sends a bit only while dump_en is seen high; stops after budget idle cycles.
  task automatic feed_bits(input logic [1:0] mask, input logic [63:0] d0, input logic [63:0] d1,
                           input int nbits, input int budget, output int fed);
    int w;
    fed = 0;
    for (int i = 0; i < nbits; i++) begin
      w = 0;
      while (dump_en[0] !== 1'b1 && w < budget) begin
        step();
        w++;
      end
      if (dump_en[0] !== 1'b1) return;
      chains_in_vld = mask;
      chains_in     = {d1[i], d0[i]};
      step();
      chains_in_vld = 2'b00;
      chains_in     = 2'b00;
      fed++;
    end
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      if (done === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({busy, word_vld, dump_en, capture_en, done, overrun} !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b expected 0000000", {busy, word_vld, dump_en, capture_en, done, overrun});
    end
    n_checks++;
    if ({word_out, word_chain, word_bits} !== 13'b0) begin
      n_bad++;
      $display("FAIL reset_word: got %h expected 0", {word_out, word_chain, word_bits});
    end
  endtask

  task automatic test_basic();
    int fed;
    bit seen;
    chains_in_done = 2'b10;
    word_rdy = 1'b1;
    start_session();
    n_checks++;
    if ({capture_en, busy} !== 2'b11) begin
      n_bad++;
      $display("FAIL t1_capture_on: got %b expected 11", {capture_en, busy});
    end
    step();
    n_checks++;
    if (capture_en !== 1'b0) begin
      n_bad++;
      $display("FAIL t1_capture_one_cycle: got %b expected 0", capture_en);
    end
    push_exp(8'hA5, 1'b0, 4'd8);
    push_exp(8'h3C, 1'b0, 4'd8);
    feed_bits(2'b01, 64'h3CA5, 64'h0, 16, 50, fed);
    n_checks++;
    if (fed !== 16) begin
      n_bad++;
      $display("FAIL t1_fed: got %0d expected 16", fed);
    end
    chains_in_done = 2'b11;
    wait_done(50, seen);
    n_checks++;
    if (seen !== 1'b1) begin
      n_bad++;
      $display("FAIL t1_done_seen: got %b expected 1", seen);
    end
    step();
    n_checks++;
    if ({done, busy} !== 2'b00) begin
      n_bad++;
      $display("FAIL t1_done_pulse: got done,busy=%b expected 00", {done, busy});
    end
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_bad++;
      $display("FAIL t1_words_left: got %0d expected 0", exp_q.size());
    end
  endtask

  task automatic test_partial();
    int fed;
    bit seen;
    chains_in_done = 2'b10;
    word_rdy = 1'b0;
    start_session();
    push_exp(8'hA5, 1'b0, 4'd8);
    push_exp(8'h05, 1'b0, 4'd3);
    feed_bits(2'b01, 64'h5A5, 64'h0, 11, 50, fed);
    chains_in_done = 2'b11;
    seen = 1'b0;
    repeat (10) begin
      step();
      if (done === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if ({seen, word_vld} !== 2'b01) begin
      n_bad++;
      $display("FAIL t2_hold_done: got seen,word_vld=%b expected 01", {seen, word_vld});
    end
    word_rdy = 1'b1;
    wait_done(50, seen);
    n_checks++;
    if (seen !== 1'b1 || exp_q.size() !== 0) begin
      n_bad++;
      $display("FAIL t2_done: got seen=%b left=%0d expected seen=1 left=0", seen, exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    int fed;
    bit seen;
    logic [63:0] d;
    d = {16'h0, 8'h0F, 8'hF0, 8'h18, 8'h24, 8'h42, 8'h81};
    chains_in_done = 2'b10;
    word_rdy = 1'b0;
    start_session();
    push_exp(8'h81, 1'b0, 4'd8);
    push_exp(8'h42, 1'b0, 4'd8);
    push_exp(8'h24, 1'b0, 4'd8);
    push_exp(8'h18, 1'b0, 4'd8);
    push_exp(8'hF0, 1'b0, 4'd8);
    push_exp(8'h0F, 1'b0, 4'd8);
    feed_bits(2'b01, d, 64'h0, 48, 20, fed);
    n_checks++;
    if (fed !== 41) begin
      n_bad++;
      $display("FAIL t3_bits_before_stall: got %0d expected 41", fed);
    end
    n_checks++;
    if ({dump_en, overrun, word_vld} !== 4'b0001) begin
      n_bad++;
      $display("FAIL t3_stalled: got dump_en,overrun,word_vld=%b expected 0001", {dump_en, overrun, word_vld});
    end
    word_rdy = 1'b1;
    feed_bits(2'b01, d >> 41, 64'h0, 7, 50, fed);
    n_checks++;
    if (fed !== 7) begin
      n_bad++;
      $display("FAIL t3_bits_after_release: got %0d expected 7", fed);
    end
    chains_in_done = 2'b11;
    wait_done(60, seen);
    n_checks++;
    if (seen !== 1'b1 || exp_q.size() !== 0 || overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL t3_end: got seen=%b left=%0d overrun=%b expected 1,0,0", seen, exp_q.size(), overrun);
    end
  endtask

  task automatic test_round_robin();
    int fed;
    bit seen;
    do_reset();
    chains_in_done = 2'b00;
    word_rdy = 1'b1;
    start_session();
    push_exp(8'h11, 1'b0, 4'd8);
    push_exp(8'h22, 1'b1, 4'd8);
    feed_bits(2'b11, 64'h11, 64'h22, 8, 50, fed);
    push_exp(8'h33, 1'b0, 4'd8);
    feed_bits(2'b01, 64'h33, 64'h0, 8, 50, fed);
    push_exp(8'h55, 1'b1, 4'd8);
    push_exp(8'h44, 1'b0, 4'd8);
    feed_bits(2'b11, 64'h44, 64'h55, 8, 50, fed);
    chains_in_done = 2'b11;
    wait_done(50, seen);
    n_checks++;
    if (seen !== 1'b1 || exp_q.size() !== 0) begin
      n_bad++;
      $display("FAIL t4_end: got seen=%b left=%0d expected seen=1 left=0", seen, exp_q.size());
    end
  endtask

  task automatic test_abort();
    int fed;
    bit seen;
    chains_in_done = 2'b00;
    word_rdy = 1'b0;
    start_session();
    feed_bits(2'b01, 64'h6_B3C5, 64'h0, 19, 50, fed);
    n_checks++;
    if (word_vld !== 1'b1) begin
      n_bad++;
      $display("FAIL t5_fifo_filled: got %b expected 1", word_vld);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if ({busy, word_vld, dump_en, done} !== 5'b0) begin
      n_bad++;
      $display("FAIL t5_abort: got busy,word_vld,dump_en,done=%b expected 00000", {busy, word_vld, dump_en, done});
    end
    seen = 1'b0;
    repeat (5) begin
      step();
      if (done === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL t5_no_done: got %b expected 0", seen);
    end
  endtask

  task automatic test_idle_overrun();
    bit seen;
    chains_in_vld = 2'b01;
    step();
    chains_in_vld = 2'b00;
    n_checks++;
    if (overrun !== 1'b1) begin
      n_bad++;
      $display("FAIL t6_overrun_set: got %b expected 1", overrun);
    end
    repeat (3) step();
    n_checks++;
    if (overrun !== 1'b1) begin
      n_bad++;
      $display("FAIL t6_overrun_sticky: got %b expected 1", overrun);
    end
    chains_in_done = 2'b11;
    start_session();
    n_checks++;
    if ({overrun, busy} !== 2'b01) begin
      n_bad++;
      $display("FAIL t6_overrun_clear: got overrun,busy=%b expected 01", {overrun, busy});
    end
    wait_done(20, seen);
    n_checks++;
    if (seen !== 1'b1) begin
      n_bad++;
      $display("FAIL t6_empty_session_done: got %b expected 1", seen);
    end
  endtask

  initial begin
    rst            = 1'b1;
    start          = 1'b0;
    word_rdy       = 1'b0;
    chains_in      = 2'b00;
    chains_in_vld  = 2'b00;
    chains_in_done = 2'b00;
    #1;
    test_reset();
    test_basic();
    test_partial();
    test_backpressure();
    test_round_robin();
    test_abort();
    test_idle_overrun();
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
